riscv_dmem_arbiter: RTL and testbench

Shares the single-port data memory between the pipeline memory stage (core port) and an external loader/debug requester (ext port).
- Core has fixed priority.
- A starvation counter forces an ext grant after a bounded wait; the core is stalled for that one cycle.
- Drives the dmem address, write-data, byte-select and write-enable inputs directly; sits between the memory stage and riscv_dmem.

---
 rtl/riscv_dmem_arbiter_pkg.sv | 14 +
 rtl/riscv_arb_starve_cnt.sv | 31 +++
 rtl/riscv_defines.sv | 10 +
 rtl/riscv_dmem_arbiter.sv | 94 +++++++++
 tb/tb_riscv_dmem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_dmem_arbiter_pkg.sv
// Constants and helpers shared by the data-memory arbiter and its counter.
`include "riscv_defines.sv"

package riscv_dmem_arbiter_pkg;

  localparam int unsigned DMEM_WORD_W = `DMEM_ADDR_BIT - 2;
  localparam int unsigned ADDR_HI_W   = `XLEN - `DMEM_ADDR_BIT;

  // Any set bit above the dmem window means the address does not exist.
  function automatic logic addr_out_of_range(input logic [ADDR_HI_W-1:0] addr_hi);
    return |addr_hi;
  endfunction

endpackage

// File: rtl/riscv_arb_starve_cnt.sv
// Saturating wait counter: counts cycles a requester is passed over and
// raises o_force once the limit is reached. Reusable by any arbiter.
module riscv_arb_starve_cnt #(
  parameter int unsigned P_MAX   = 4,
  parameter int unsigned P_CNT_W = 3
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_clr,
  output logic o_force
);

  localparam logic [P_CNT_W-1:0] CNT_MAX = P_CNT_W'(P_MAX);

  logic [P_CNT_W-1:0] cnt;

  assign o_force = (cnt == CNT_MAX);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, matching real hardware.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt <= '0;
    end else if (i_clr) begin
      cnt <= '0;
    end else if (!o_force) begin
      cnt <= cnt + P_CNT_W'(1);
    end
  end

endmodule

// File: rtl/riscv_defines.sv
// Shared RISC-V core defines: datapath width and data-memory geometry.
// Guarded so every file can include it regardless of compile order.
`ifndef RISCV_DEFINES_SV
`define RISCV_DEFINES_SV

`define XLEN                32
`define DMEM_ADDR_BIT       12
`define DMEM_ARB_STARVE_MAX 4

`endif

// File: rtl/riscv_dmem_arbiter.sv
// Single-port dmem arbiter: core has fixed priority, the ext loader/debug
// port gets a forced grant after a bounded wait, stalling the core one cycle.
`include "riscv_defines.sv"

module riscv_dmem_arbiter
  import riscv_dmem_arbiter_pkg::*;
#(
  parameter int unsigned P_STARVE_MAX = `DMEM_ARB_STARVE_MAX,
  parameter int unsigned P_CNT_W      = 3
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic [`XLEN-1:0]          i_core_addr,
  input  logic [`XLEN-1:0]          i_core_wdata,
  input  logic [3:0]                i_core_byte_sel,
  input  logic                      i_core_wr_en,
  input  logic                      i_core_rd_en,
  output logic [`XLEN-1:0]          o_core_rdata,
  output logic                      o_core_stall,
  input  logic                      i_ext_valid,
  output logic                      o_ext_ready,
  input  logic                      i_ext_we,
  input  logic [`XLEN-1:0]          i_ext_addr,
  input  logic [`XLEN-1:0]          i_ext_wdata,
  input  logic [3:0]                i_ext_byte_sel,
  output logic                      o_ext_rvalid,
  output logic [`XLEN-1:0]          o_ext_rdata,
  output logic                      o_ext_err,
  output logic [`DMEM_ADDR_BIT-3:0] o_dmem_addr,
  output logic [`XLEN-1:0]          o_dmem_wdata,
  output logic [3:0]                o_dmem_byte_sel,
  output logic                      o_dmem_wr_en,
  input  logic [`XLEN-1:0]          i_dmem_rdata
);

  logic core_req;
  logic ext_gnt;
  logic ext_err_now;
  logic force_gnt;
  logic unused_addr_bits;

  assign core_req    = i_core_wr_en | i_core_rd_en;
  assign ext_err_now = addr_out_of_range(i_ext_addr[`XLEN-1:`DMEM_ADDR_BIT]);
  assign ext_gnt     = i_ext_valid & (~core_req | force_gnt);

  assign o_ext_ready  = ext_gnt;
  assign o_core_stall = core_req & ext_gnt;
  assign o_core_rdata = i_dmem_rdata;

  // Byte offsets and the unchecked core high bits do not reach the memory.
  assign unused_addr_bits = ^{i_core_addr[`XLEN-1:`DMEM_ADDR_BIT], i_core_addr[1:0],
                              i_ext_addr[1:0]};

  riscv_arb_starve_cnt #(
    .P_MAX   (P_STARVE_MAX),
    .P_CNT_W (P_CNT_W)
  ) u_starve_cnt (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_clr   (ext_gnt | ~i_ext_valid),
    .o_force (force_gnt)
  );

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    o_dmem_addr     = i_core_addr[`DMEM_ADDR_BIT-1:2];
    o_dmem_wdata    = i_core_wdata;
    o_dmem_byte_sel = i_core_byte_sel;
    o_dmem_wr_en    = i_core_wr_en;
    if (ext_gnt) begin
      o_dmem_addr     = i_ext_addr[`DMEM_ADDR_BIT-1:2];
      o_dmem_wdata    = i_ext_wdata;
      o_dmem_byte_sel = i_ext_byte_sel;
      o_dmem_wr_en    = i_ext_we & ~ext_err_now;
    end
  end

  // Ext response is captured on the grant edge; data only for in-range reads.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_ext_rvalid <= 1'b0;
      o_ext_rdata  <= '0;
      o_ext_err    <= 1'b0;
    end else begin
      o_ext_rvalid <= ext_gnt;
      if (ext_gnt) begin
        o_ext_rdata <= (i_ext_we | ext_err_now) ? '0 : i_dmem_rdata;
        o_ext_err   <= ext_err_now;
      end
    end
  end

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Scoreboard bench for riscv_dmem_arbiter: directed stimulus pushes expected
// ext responses, a monitor pops them whenever o_ext_rvalid is seen.
`include "riscv_defines.sv"

module tb_riscv_dmem_arbiter;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  logic        clk;
  logic        rstn;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic [3:0]  core_byte_sel;
  logic        core_wr_en, core_rd_en, core_stall;
  logic        ext_valid, ext_ready, ext_we, ext_rvalid, ext_err;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
  logic [3:0]  ext_byte_sel;
  logic [`DMEM_ADDR_BIT-3:0] dmem_addr;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_byte_sel;
  logic        dmem_wr_en;

  logic [31:0] mem [0:(1 << (`DMEM_ADDR_BIT - 2)) - 1];
  resp_t       exp_q [$];
  int          n_total = 0;
  int          n_pass  = 0;

  riscv_dmem_arbiter #(.P_STARVE_MAX(4), .P_CNT_W(3)) dut (
    .i_clk           (clk),
    .i_rstn          (rstn),
    .i_core_addr     (core_addr),
    .i_core_wdata    (core_wdata),
    .i_core_byte_sel (core_byte_sel),
    .i_core_wr_en    (core_wr_en),
    .i_core_rd_en    (core_rd_en),
    .o_core_rdata    (core_rdata),
    .o_core_stall    (core_stall),
    .i_ext_valid     (ext_valid),
    .o_ext_ready     (ext_ready),
    .i_ext_we        (ext_we),
    .i_ext_addr      (ext_addr),
    .i_ext_wdata     (ext_wdata),
    .i_ext_byte_sel  (ext_byte_sel),
    .o_ext_rvalid    (ext_rvalid),
    .o_ext_rdata     (ext_rdata),
    .o_ext_err       (ext_err),
    .o_dmem_addr     (dmem_addr),
    .o_dmem_wdata    (dmem_wdata),
    .o_dmem_byte_sel (dmem_byte_sel),
    .o_dmem_wr_en    (dmem_wr_en),
    .i_dmem_rdata    (dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port dmem: asynchronous read, byte-lane write.
  assign dmem_rdata = mem[dmem_addr];
  always @(posedge clk) begin
    if (dmem_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (dmem_byte_sel[b]) mem[dmem_addr][8*b +: 8] <= dmem_wdata[8*b +: 8];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_total++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
  endtask

  task automatic drive_core(input logic wr, input logic rd, input logic [31:0] addr,
                            input logic [31:0] wdata);
    core_wr_en    = wr;
    core_rd_en    = rd;
    core_addr     = addr;
    core_wdata    = wdata;
    core_byte_sel = 4'hF;
  endtask

  task automatic drive_ext(input logic valid, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
    ext_valid    = valid;
    ext_we       = we;
    ext_addr     = addr;
    ext_wdata    = wdata;
    ext_byte_sel = 4'hF;
  endtask

  task automatic expect_resp(input logic [31:0] rdata, input logic err);
    resp_t r;
    r.rdata = rdata;
    r.err   = err;
    exp_q.push_back(r);
  endtask

  // Monitor: every rvalid pulse must match the oldest expected response.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (ext_rvalid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_rvalid: got rvalid=1, expected no response at %0t", $time);
        end else begin
          r = exp_q.pop_front();
          check("ext_rdata", ext_rdata, r.rdata);
          check("ext_err", {31'd0, ext_err}, {31'd0, r.err});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] oor_addr;
    logic        exp_rdy;
    logic        ext_seq [8];

    oor_addr = 32'd1 << `DMEM_ADDR_BIT;
    for (int i = 0; i < (1 << (`DMEM_ADDR_BIT - 2)); i++) mem[i] = 32'd0;
    rstn = 1'b0;
    drive_core(1'b0, 1'b0, 32'd0, 32'd0);
    drive_ext(1'b0, 1'b0, 32'd0, 32'd0);

    // Reset state
    @(negedge clk);
    check("rst_rvalid", {31'd0, ext_rvalid}, 32'd0);
    check("rst_rdata", ext_rdata, 32'd0);
    check("rst_err", {31'd0, ext_err}, 32'd0);
    rstn = 1'b1;

    // Core store then load of 0x10
    @(negedge clk);
    drive_core(1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
    #1;
    check("core_st_addr", {22'd0, dmem_addr}, 32'd4);
    check("core_st_wr_en", {31'd0, dmem_wr_en}, 32'd1);
    check("core_st_wdata", dmem_wdata, 32'hDEADBEEF);
    check("core_st_stall", {31'd0, core_stall}, 32'd0);
    @(negedge clk);
    drive_core(1'b0, 1'b1, 32'h10, 32'd0);
    #1;
    check("core_ld_rdata", core_rdata, 32'hDEADBEEF);
    check("core_ld_wr_en", {31'd0, dmem_wr_en}, 32'd0);

    // Ext read with idle core
    @(negedge clk);
    drive_core(1'b0, 1'b0, 32'd0, 32'd0);
    drive_ext(1'b1, 1'b0, 32'h10, 32'd0);
    #1;
    check("ext_rd_ready", {31'd0, ext_ready}, 32'd1);
    check("ext_rd_addr", {22'd0, dmem_addr}, 32'd4);
    expect_resp(32'hDEADBEEF, 1'b0);
    @(negedge clk);
    drive_ext(1'b0, 1'b0, 32'd0, 32'd0);

    // Starvation: continuous core stores, ext write forced every 5th cycle
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive_core(1'b1, 1'b0, 32'h20, 32'h11111111);
      drive_ext(1'b1, 1'b1, 32'h24, 32'hCAFEF00D);
      #1;
      exp_rdy = (c == 4) || (c == 9);
      check($sformatf("starve_ready_c%0d", c), {31'd0, ext_ready}, {31'd0, exp_rdy});
      check($sformatf("starve_stall_c%0d", c), {31'd0, core_stall}, {31'd0, exp_rdy});
      check($sformatf("starve_addr_c%0d", c), {22'd0, dmem_addr}, exp_rdy ? 32'd9 : 32'd8);
      if (exp_rdy) begin
        check("starve_ext_wdata", dmem_wdata, 32'hCAFEF00D);
        check("starve_ext_wr_en", {31'd0, dmem_wr_en}, 32'd1);
        expect_resp(32'd0, 1'b0);
      end
    end
    @(negedge clk);
    drive_ext(1'b0, 1'b0, 32'd0, 32'd0);
    drive_core(1'b0, 1'b1, 32'h24, 32'd0);
    #1;
    check("starve_ext_landed", core_rdata, 32'hCAFEF00D);
    @(negedge clk);
    drive_core(1'b0, 1'b1, 32'h20, 32'd0);
    #1;
    check("starve_core_landed", core_rdata, 32'h11111111);

    // Out-of-range ext write, out-of-range read, then in-range read back-to-back
    @(negedge clk);
    drive_core(1'b0, 1'b0, 32'd0, 32'd0);
    drive_ext(1'b1, 1'b1, oor_addr, 32'h55555555);
    #1;
    check("oor_wr_ready", {31'd0, ext_ready}, 32'd1);
    check("oor_wr_en", {31'd0, dmem_wr_en}, 32'd0);
    expect_resp(32'd0, 1'b1);
    @(negedge clk);
    drive_ext(1'b1, 1'b0, oor_addr, 32'd0);
    #1;
    check("oor_rd_ready", {31'd0, ext_ready}, 32'd1);
    expect_resp(32'd0, 1'b1);
    @(negedge clk);
    drive_ext(1'b1, 1'b0, 32'h10, 32'd0);
    #1;
    check("b2b_rd_ready", {31'd0, ext_ready}, 32'd1);
    expect_resp(32'hDEADBEEF, 1'b0);
    @(negedge clk);
    drive_ext(1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    check("oor_mem0_intact", core_rdata, 32'd0);

    // Withdrawn request: counter restarts on re-assertion
    ext_seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      drive_core(1'b0, 1'b1, 32'h10, 32'd0);
      drive_ext(ext_seq[c], 1'b0, 32'h10, 32'd0);
      #1;
      exp_rdy = (c == 7);
      check($sformatf("withdraw_ready_c%0d", c), {31'd0, ext_ready}, {31'd0, exp_rdy});
      if (exp_rdy) begin
        check("withdraw_stall", {31'd0, core_stall}, 32'd1);
        expect_resp(32'hDEADBEEF, 1'b0);
      end
    end

    // Reset between grant edge and rvalid cycle kills the response
    @(negedge clk);
    drive_core(1'b0, 1'b0, 32'd0, 32'd0);
    drive_ext(1'b1, 1'b0, 32'h24, 32'd0);
    #1;
    check("rstmid_ready", {31'd0, ext_ready}, 32'd1);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("rstmid_rvalid", {31'd0, ext_rvalid}, 32'd0);
    check("rstmid_rdata", ext_rdata, 32'd0);
    @(negedge clk);
    drive_ext(1'b0, 1'b0, 32'd0, 32'd0);
    rstn = 1'b1;

    // Counter built up to 3, reset mid-wait clears it
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive_core(1'b1, 1'b0, 32'h20, 32'h11111111);
      drive_ext(1'b1, 1'b0, 32'h20, 32'd0);
      #1;
      check($sformatf("prerst_ready_c%0d", c), {31'd0, ext_ready}, 32'd0);
    end
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("inrst_ready", {31'd0, ext_ready}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      exp_rdy = (c == 4);
      check($sformatf("postrst_ready_c%0d", c), {31'd0, ext_ready}, {31'd0, exp_rdy});
      if (exp_rdy) expect_resp(32'h11111111, 1'b0);
    end
    @(negedge clk);
    drive_core(1'b0, 1'b0, 32'd0, 32'd0);
    drive_ext(1'b0, 1'b0, 32'd0, 32'd0);

    // Drain: every expected response must have been observed
    repeat (3) @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
